// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port, 1-cycle sync-read data memory between the core
//   load/store unit (port C) and the debug dump/DMA engine (port D).
//   C has fixed priority; a starvation counter forces a D grant after
//   STARVE_LIMIT consecutive denied D-request grant opportunities.
//   Each accepted request is issued to memory one cycle after its grant and
//   acknowledged (rvalid/rdata) to its owner two cycles after its grant.
//
// Ports
//   clk, reset            clock (rising edge) and asynchronous active-low reset
//   c_req/c_we/c_be/      core request and its fields (held until c_gnt)
//   c_addr/c_wdata
//   c_gnt                 combinational 1-cycle accept pulse
//   c_rvalid/c_rdata      1-cycle ack; rdata = read data, 0 for write acks
//   d_*                   same set for the debug port
//   mem_en/mem_we/mem_be/ memory strobe, write enable, byte enables,
//   mem_addr/mem_wdata    word address and write data (all 0 when mem_en=0)
//   mem_rdata             memory read data, valid the cycle after mem_en

module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                c_req,
  input  logic                c_we,
  input  logic [DATA_W/8-1:0] c_be,
  input  logic [ADDR_W-1:0]   c_addr,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic                c_gnt,
  output logic                c_rvalid,
  output logic [DATA_W-1:0]   c_rdata,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,

  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned WADDR_W = ADDR_W - 2;
  localparam int unsigned CNT_W   = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;

  // Fields of the access in flight; stable from the grant edge through RESP,
  // so the response decode in RESP still sees the old owner even when a new
  // grant is taken in the same cycle.
  logic               acc_owner;
  logic               acc_we;
  logic [BE_W-1:0]    acc_be;
  logic [WADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0]  acc_wdata;

  logic starve_hit;
  logic pick_c;
  logic pick_d;

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[1:0], d_addr[1:0]};

  // Winner selection: forced D at the starvation limit, else C first.
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign pick_d     = d_req & (starve_hit | ~c_req);
  assign pick_c     = c_req & ~(starve_hit & d_req);

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Capture the winner's fields on the grant edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_owner <= OWN_C;
      acc_we    <= 1'b0;
      acc_be    <= '0;
      acc_addr  <= '0;
      acc_wdata <= '0;
    end else if (c_gnt || d_gnt) begin
      acc_owner <= d_gnt ? OWN_D : OWN_C;
      acc_we    <= d_gnt ? d_we : c_we;
      acc_be    <= d_gnt ? d_be : c_be;
      acc_addr  <= d_gnt ? d_addr[ADDR_W-1:2] : c_addr[ADDR_W-1:2];
      acc_wdata <= d_gnt ? d_wdata : c_wdata;
    end
  end

  // Next state, counter update and all decoded outputs.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    c_gnt      = 1'b0;
    d_gnt      = 1'b0;
    c_rvalid   = 1'b0;
    c_rdata    = '0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;

    // Acknowledge the access issued last cycle.
    if (state == S_RESP) begin
      if (acc_owner == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = acc_we ? '0 : mem_rdata;
      end else begin
        c_rvalid = 1'b1;
        c_rdata  = acc_we ? '0 : mem_rdata;
      end
    end

    case (state)
      S_IDLE, S_RESP: begin
        // Grant is gated by reset so nothing is accepted while held in reset.
        state_nxt = S_IDLE;
        if (reset && (c_req || d_req)) begin
          c_gnt     = pick_c;
          d_gnt     = pick_d;
          state_nxt = S_ACCESS;
          if (pick_d) begin
            starve_nxt = '0;
          end else if (d_req && !starve_hit) begin
            starve_nxt = starve_cnt + CNT_W'(1);
          end
        end
      end
      S_ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = acc_we;
        mem_be    = acc_be;
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
        state_nxt = S_RESP;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
